// File: rtl/dds_fun_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : dds_fun_gen_if
//  Description : Control and sample bus of the DDS function generator.
//                The controller drives increment, offset, mode and strobes.
//                The generator returns the sample, the aligned phase and valid.
//  Revision    : 1.0  initial release
// ============================================================================
interface dds_fun_gen_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 10,
    parameter int DW    = 8
);
    logic [WIDTH-1:0]     M;
    logic                 m_load;
    logic [WIDTH-1:0]     P;
    logic [1:0]           mode;
    logic                 ena;
    logic                 sync;
    logic signed [DW-1:0] wave;
    logic [AW-1:0]        acc;
    logic                 valid;

    modport master (
        output M, m_load, P, mode, ena, sync,
        input  wave, acc, valid
    );

    modport slave (
        input  M, m_load, P, mode, ena, sync,
        output wave, acc, valid
    );
endinterface
`default_nettype wire

// File: rtl/dds_fun_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dds_fun_gen
//  Description : Multi-waveform DDS function generator. Phase accumulator,
//                phase offset, quarter-wave sine table, sawtooth, triangle
//                and square modes; fixed 3-stage output pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_fun_gen #(
    parameter int WIDTH = 32,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic         clk,
    input  logic         reset,
    dds_fun_gen_if.slave bus
);

    localparam logic [1:0]    c_MODE_SINE = 2'd0;
    localparam logic [1:0]    c_MODE_SAW  = 2'd1;
    localparam logic [1:0]    c_MODE_TRI  = 2'd2;
    localparam logic [1:0]    c_MODE_SQR  = 2'd3;
    localparam int            c_QW        = 2 ** (AW - 2);
    localparam int            c_NB        = (AW > DW + 1) ? AW : DW + 1;
    localparam logic [DW-1:0] c_AMP       = DW'((1 << (DW - 1)) - 1);

    // Quarter-wave sample k = round(AMP * sin(pi*(2k+1)/2**AW)), evaluated at
    // elaboration with a Q30 Taylor series so no external table file is needed.
    function automatic logic [DW-2:0] f_sine_word(input int k);
        longint     x;
        longint     x2;
        longint     term;
        longint     sum;
        logic [63:0] rnd;
        x    = (64'sd3373259426 * longint'(2 * k + 1)) >>> AW;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        rnd = 64'((longint'(c_AMP) * sum + 64'sd536870912) >>> 30);
        return rnd[DW-2:0];
    endfunction

    logic [DW-2:0] w_tab [c_QW];

    for (genvar k = 0; k < c_QW; k++) begin : g_tab
        localparam logic [DW-2:0] c_WORD = f_sine_word(k);
        assign w_tab[k] = c_WORD;
    end

    // Accumulator, increment and valid pipeline
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_inc;
    logic [2:0]           r_vld;
    // Stage 1
    logic [WIDTH-1:0]     r_ph;
    logic [1:0]           r_mode1;
    logic [AW-1:0]        r_acc1;
    // Stage 2
    logic                 r_neg2;
    logic [AW-3:0]        r_idx2;
    logic                 r_sine2;
    logic [DW-1:0]        r_alt2;
    logic [AW-1:0]        r_acc2;
    // Stage 3
    logic signed [DW-1:0] r_wave;
    logic [AW-1:0]        r_acc3;

    // Accumulator: sync clears and wins over ena; new increment is used from the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_inc <= '0;
            r_vld <= '0;
        end else begin
            if (bus.sync) begin
                r_a <= '0;
            end else if (bus.ena) begin
                r_a <= r_a + r_inc;
            end
            if (bus.m_load) begin
                r_inc <= bus.M;
            end
            r_vld <= {r_vld[1:0], 1'b1};
        end
    end

    // Stage 1: offset phase plus mode and accumulator phase travel together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph    <= '0;
            r_mode1 <= c_MODE_SINE;
            r_acc1  <= '0;
        end else begin
            r_ph    <= r_a + bus.P;
            r_mode1 <= bus.mode;
            r_acc1  <= r_a[WIDTH-1 -: AW];
        end
    end

    logic [1:0]    w_q;
    logic [AW-3:0] w_idx_raw;
    logic [AW-3:0] w_idx;
    logic [DW-1:0] w_saw;
    logic [DW-1:0] w_t;
    logic [DW-1:0] w_u;
    logic [DW-1:0] w_tri;
    logic [DW-1:0] w_sqr;
    logic [DW-1:0] w_alt;
    logic          w_unused_ph;

    assign w_q         = r_ph[WIDTH-1:WIDTH-2];
    assign w_idx_raw   = r_ph[WIDTH-3:WIDTH-AW];
    assign w_idx       = w_q[0] ? ~w_idx_raw : w_idx_raw;
    assign w_saw       = {~r_ph[WIDTH-1], r_ph[WIDTH-2 -: DW-1]};
    assign w_t         = r_ph[WIDTH-2 -: DW];
    assign w_u         = r_ph[WIDTH-1] ? ~w_t : w_t;
    assign w_tri       = {~w_u[DW-1], w_u[DW-2:0]};
    assign w_sqr       = r_ph[WIDTH-1] ? -c_AMP : c_AMP;
    assign w_unused_ph = ^r_ph[WIDTH-c_NB-1:0];

    // Non-sine waveforms are fully formed in stage 2 and only carried through stage 3.
    always_comb begin
        w_alt = w_saw;
        case (r_mode1)
            c_MODE_SAW: w_alt = w_saw;
            c_MODE_TRI: w_alt = w_tri;
            c_MODE_SQR: w_alt = w_sqr;
            default:    w_alt = w_saw;
        endcase
    end

    // Stage 2: folded table index, half-wave sign and alternate waveform.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg2  <= 1'b0;
            r_idx2  <= '0;
            r_sine2 <= 1'b0;
            r_alt2  <= '0;
            r_acc2  <= '0;
        end else begin
            r_neg2  <= w_q[1];
            r_idx2  <= w_idx;
            r_sine2 <= (r_mode1 == c_MODE_SINE);
            r_alt2  <= w_alt;
            r_acc2  <= r_acc1;
        end
    end

    logic [DW-1:0] w_mag;
    assign w_mag = {1'b0, w_tab[r_idx2]};

    // Stage 3: table lookup with sign applied, or the carried waveform.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wave <= '0;
            r_acc3 <= '0;
        end else begin
            if (r_sine2) begin
                r_wave <= r_neg2 ? -w_mag : w_mag;
            end else begin
                r_wave <= r_alt2;
            end
            r_acc3 <= r_acc2;
        end
    end

    assign bus.wave  = r_wave;
    assign bus.acc   = r_acc3;
    assign bus.valid = r_vld[2];

endmodule
`default_nettype wire
